// File: rtl/w_feed_pkg.sv
// Shared definitions for the FIFO write-side sources: default widths and the
// feed FSM state encoding with its next-state rule.
package w_feed_pkg;

    localparam int DW_DEF = 8;
    localparam int CW_DEF = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_XFER = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // State follows the occupancy after this edge and the current full flag.
    function automatic logic [1:0] feed_next_state(input logic [1:0] count_nxt,
                                                   input logic       full);
        logic [1:0] st;
        if (count_nxt == 2'd0) begin
            st = ST_IDLE;
        end else if (full) begin
            st = ST_HOLD;
        end else begin
            st = ST_XFER;
        end
        return st;
    endfunction

endpackage

// File: rtl/w_skid.sv
// Two-entry FIFO buffer of {data,last}. The head is presented combinationally;
// the caller guarantees push only when count!=2 and pop only when count!=0.
module w_skid
    import w_feed_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          w_clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          push_last,
    input  logic          pop,
    output logic [DW-1:0] head_data,
    output logic          head_last,
    output logic [1:0]    count,
    output logic [1:0]    count_nxt
);

    logic [DW-1:0] data_q [2];
    logic [DW-1:0] data_d [2];
    logic          last_q [2];
    logic          last_d [2];
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    count_q, count_d;

    always_comb begin
        data_d   = data_q;
        last_d   = last_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            data_d[wr_ptr_q] = push_data;
            last_d[wr_ptr_q] = push_last;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    // Storage carries no reset; only pointers and occupancy are cleared.
    always_ff @(posedge w_clk) begin
        data_q <= data_d;
        last_q <= last_d;
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = data_q[rd_ptr_q];
    assign head_last = last_q[rd_ptr_q];
    assign count     = count_q;
    assign count_nxt = count_d;

endmodule

// File: rtl/w_feed.sv
// Stream-to-FIFO write feeder: buffers source words in a 2-entry skid buffer,
// writes them whenever the FIFO is not full, and counts words and frames.
module w_feed
    import w_feed_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic          w_clk,
    input  logic          rst,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          s_ready,
    input  logic          w_full,
    output logic          w_en,
    output logic [DW-1:0] w_data,
    output logic          w_last,
    output logic [CW-1:0] word_cnt,
    output logic [CW-1:0] frame_cnt,
    output logic          stall
);

    logic [1:0]    count;
    logic [1:0]    count_nxt;
    logic          accept;
    logic          wr;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] word_cnt_q, word_cnt_d;
    logic [CW-1:0] frame_cnt_q, frame_cnt_d;

    // s_ready depends only on registered occupancy, never on w_full.
    assign s_ready = (count != 2'd2);
    assign accept  = s_valid & s_ready;
    assign wr      = (count != 2'd0) & ~w_full;

    w_skid #(.DW(DW)) u_skid (
        .w_clk     (w_clk),
        .rst       (rst),
        .push      (accept),
        .push_data (s_data),
        .push_last (s_last),
        .pop       (wr),
        .head_data (w_data),
        .head_last (w_last),
        .count     (count),
        .count_nxt (count_nxt)
    );

    always_comb begin
        state_d     = feed_next_state(count_nxt, w_full);
        word_cnt_d  = word_cnt_q;
        frame_cnt_d = frame_cnt_q;
        if (wr) begin
            word_cnt_d = word_cnt_q + CW'(1);
            if (w_last) begin
                frame_cnt_d = frame_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge w_clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            word_cnt_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            word_cnt_q  <= word_cnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign w_en      = wr;
    assign stall     = (state_q == ST_HOLD);
    assign word_cnt  = word_cnt_q;
    assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_w_feed.sv
// Directed bench for w_feed (DW=8, CW=4): stream, backpressure, simultaneous
// accept/write, counter wrap, mid-frame reset and full-flag toggling.
module tb_w_feed;

    localparam int DW = 8;
    localparam int CW = 4;

    logic          w_clk;
    logic          rst;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_last;
    logic          s_ready;
    logic          w_full;
    logic          w_en;
    logic [DW-1:0] w_data;
    logic          w_last;
    logic [CW-1:0] word_cnt;
    logic [CW-1:0] frame_cnt;
    logic          stall;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] got_d [$];
    logic          got_l [$];

    w_feed #(.DW(DW), .CW(CW)) dut (
        .w_clk     (w_clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .w_full    (w_full),
        .w_en      (w_en),
        .w_data    (w_data),
        .w_last    (w_last),
        .word_cnt  (word_cnt),
        .frame_cnt (frame_cnt),
        .stall     (stall)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    // Record every FIFO write mid-cycle, away from the active edge.
    always @(negedge w_clk) begin
        if (w_en) begin
            got_d.push_back(w_data);
            got_l.push_back(w_last);
        end
    end

    task automatic step();
        @(posedge w_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic clear_log();
        got_d.delete();
        got_l.delete();
    endtask

    initial begin
        int idx;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        w_full  = 1'b0;
        step();
        step();
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_w_en", 32'(w_en), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        rst = 1'b0;
        step();
        chk("idle_w_en", 32'(w_en), 32'd0);

        // Stream of five words, last on 0x15
        clear_log();
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = 8'h11 + 8'(i);
            s_last  = (i == 4);
            step();
            chk("stream_w_en", 32'(w_en), 32'd1);
            chk("stream_w_data", 32'(w_data), 32'h11 + 32'(i));
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        step();
        step();
        chk("stream_n", 32'(got_d.size()), 32'd5);
        for (int i = 0; i < 5 && i < got_d.size(); i++) begin
            chk("stream_data", 32'(got_d[i]), 32'h11 + 32'(i));
            chk("stream_last", 32'(got_l[i]), (i == 4) ? 32'd1 : 32'd0);
        end
        chk("stream_word_cnt", 32'(word_cnt), 32'd5);
        chk("stream_frame_cnt", 32'(frame_cnt), 32'd1);

        // Backpressure: three offered under full, two taken
        do_reset();
        clear_log();
        w_full  = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hA0;
        step();
        chk("bp_w_en_1", 32'(w_en), 32'd0);
        s_data = 8'hA1;
        step();
        chk("bp_s_ready_full", 32'(s_ready), 32'd0);
        s_data = 8'hA2;
        step();
        chk("bp_s_ready", 32'(s_ready), 32'd0);
        chk("bp_stall", 32'(stall), 32'd1);
        chk("bp_w_en", 32'(w_en), 32'd0);
        chk("bp_hold_data", 32'(w_data), 32'hA0);
        step();
        chk("bp_hold_data_2", 32'(w_data), 32'hA0);
        s_valid = 1'b0;
        w_full  = 1'b0;
        #1;
        chk("bp_rel_w_en", 32'(w_en), 32'd1);
        chk("bp_rel_data0", 32'(w_data), 32'hA0);
        step();
        chk("bp_rel_w_en_2", 32'(w_en), 32'd1);
        chk("bp_rel_data1", 32'(w_data), 32'hA1);
        chk("bp_rel_s_ready", 32'(s_ready), 32'd1);
        step();
        chk("bp_drained", 32'(w_en), 32'd0);
        chk("bp_n", 32'(got_d.size()), 32'd2);
        chk("bp_word_cnt", 32'(word_cnt), 32'd2);

        // Simultaneous accept and write with one word held
        s_valid = 1'b1;
        s_data  = 8'h30;
        step();
        for (int i = 1; i <= 5; i++) begin
            s_data = 8'h30 + 8'(i);
            chk("sim_w_en", 32'(w_en), 32'd1);
            chk("sim_head", 32'(w_data), 32'h30 + 32'(i - 1));
            chk("sim_s_ready", 32'(s_ready), 32'd1);
            step();
        end
        s_valid = 1'b0;
        chk("sim_last_head", 32'(w_data), 32'h35);
        step();
        chk("sim_empty", 32'(w_en), 32'd0);
        chk("sim_word_cnt", 32'(word_cnt), 32'd8);

        // Word counter wrap at 2^CW
        do_reset();
        s_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            s_data = 8'(i);
            step();
        end
        s_valid = 1'b0;
        step();
        step();
        chk("wrap_word_cnt", 32'(word_cnt), 32'd1);
        chk("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

        // Reset with two words held under full
        w_full  = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hB0;
        step();
        s_data = 8'hB1;
        step();
        chk("mr_full", 32'(s_ready), 32'd0);
        rst = 1'b1;
        s_valid = 1'b0;
        step();
        rst    = 1'b0;
        w_full = 1'b0;
        #1;
        chk("mr_w_en", 32'(w_en), 32'd0);
        chk("mr_s_ready", 32'(s_ready), 32'd1);
        chk("mr_stall", 32'(stall), 32'd0);
        chk("mr_word_cnt", 32'(word_cnt), 32'd0);
        chk("mr_frame_cnt", 32'(frame_cnt), 32'd0);
        step();
        chk("mr_w_en_2", 32'(w_en), 32'd0);

        // Full toggling every cycle through an 8-word frame
        clear_log();
        idx = 0;
        for (int c = 0; c < 60; c++) begin
            w_full  = c[0];
            s_valid = (idx < 8);
            s_data  = 8'hC0 + 8'(idx);
            s_last  = (idx == 7);
            if (s_valid && s_ready) begin
                idx++;
            end
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        w_full  = 1'b0;
        step();
        step();
        chk("tog_accepted", 32'(idx), 32'd8);
        chk("tog_n", 32'(got_d.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_d.size(); i++) begin
            chk("tog_data", 32'(got_d[i]), 32'hC0 + 32'(i));
            chk("tog_last", 32'(got_l[i]), (i == 7) ? 32'd1 : 32'd0);
        end
        chk("tog_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("tog_word_cnt", 32'(word_cnt), 32'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/w_feed.md
W_FEED -- requirements
Module: w_feed

Interface
REQ-001 Parameter DW, default 8, SHALL set the data width of s_data and w_data.
REQ-002 Parameter CW, default 8, SHALL set the width of the word and frame counters.
REQ-003 w_clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 s_valid  input  1  SHALL mark the source word as valid.
REQ-006 s_data  input  DW  SHALL carry the source word.
REQ-007 s_last  input  1  SHALL mark the final word of a frame.
REQ-008 s_ready  output  1  SHALL indicate the block can accept a word this cycle.
REQ-009 w_full  input  1  SHALL carry the full flag from the FIFO write controller in the w_clk domain.
REQ-010 w_en  output  1  SHALL be the FIFO write enable.
REQ-011 w_data  output  DW  SHALL be the FIFO write data, valid when w_en=1.
REQ-012 w_last  output  1  SHALL mark the word on w_data as end of frame.
REQ-013 word_cnt  output  CW  SHALL count words written to the FIFO.
REQ-014 frame_cnt  output  CW  SHALL count frames written to the FIFO.
REQ-015 stall  output  1  SHALL be high while data is held and w_full=1.

Function
REQ-016 Source transfer SHALL occur when s_valid=1 and s_ready=1 in the same cycle.
REQ-017 The block SHALL hold a 2-entry buffer of {data,last}, with a 2-bit occupancy count of 0..2.
- s_ready SHALL be (count!=2), derived only from registered state, with no combinational path from w_full or s_valid.
REQ-018 FIFO write SHALL occur when count!=0 and w_full=0.
- w_en=1; w_data and w_last driven combinationally from the buffer head.
- When w_full=1, w_en SHALL be 0.
REQ-019 Latency: a word accepted at edge N into an empty buffer SHALL appear with w_en=1 in the cycle after edge N, when w_full=0.
REQ-020 A simultaneous accept and write SHALL leave count unchanged and preserve order, first in first out.
- With count=2, no accept is possible; a write SHALL reduce count to 1.
REQ-021 The FSM SHALL have states IDLE, XFER and HOLD.
- IDLE: count=0.
- XFER: count>0 and w_full=0.
- HOLD: count>0 and w_full=1.
- Transitions are re-evaluated every cycle from the next count and w_full.
- stall SHALL be 1 only in HOLD.
REQ-022 word_cnt SHALL increment by 1 per FIFO write and wrap from 2^CW-1 to 0.
REQ-023 frame_cnt SHALL increment by 1 per FIFO write with w_last=1 and wrap modulo 2^CW.
REQ-024 Words SHALL never be dropped or duplicated; w_full toggling mid-frame SHALL only pause output.
REQ-025 A stall of any length SHALL keep w_data and w_last stable until written.

Reset
REQ-026 While rst=1 at a rising edge, the block SHALL reach the following state: count=0, FSM=IDLE, word_cnt=0, frame_cnt=0.
REQ-027 During and after reset, the outputs SHALL read as follows until the first accept: s_ready=1, w_en=0, stall=0.
REQ-028 Reset asserted mid-frame SHALL discard buffered words, with no w_en in the cycle following the reset edge.

Structure
REQ-029 The FSM state encoding (IDLE=0, XFER=1, HOLD=2) and the default DW and CW SHALL reside in a shared package used by the FIFO sources.
REQ-030 The 2-entry buffer SHALL be a sub-module, w_skid, containing the storage, the pointers and count; the FSM and counters SHALL remain in w_feed.

Verification
REQ-031 Stream: hold w_full=0 and send 5 words 0x11..0x15, s_last on 0x15 -> 5 w_en pulses in order, w_last on 0x15, word_cnt=5, frame_cnt=1.
REQ-032 Backpressure: hold w_full=1 and offer 3 words -> 2 accepted, s_ready=0, stall=1, w_en=0.
- Then release w_full -> 0xA0 and 0xA1 written on consecutive cycles, s_ready=1 after the first write.
REQ-033 Simultaneous: with count=1 and w_full=0, keep s_valid=1 continuously -> count stays 1 and one word is written per cycle, in order.
REQ-034 Wrap: with CW=4, write 17 words -> word_cnt=1.
REQ-035 Mid-frame reset: with count=2 and w_full=1, assert rst for one cycle -> count=0, w_en=0 after w_full drops, counters=0.
REQ-036 Full toggle: alternate w_full every cycle during an 8-word frame -> all 8 words delivered once, in order, frame_cnt=1.
